// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with programmable wait states, illegal-access flag and debug counters
//   clk, rst            : clock, asynchronous active-high reset
//   mem_ren, mem_wen    : read / write request from the MEM stage
//   mem_addr            : byte address; word index is mem_addr[ADDR_WIDTH+1:2]
//   mem_dout            : write data from the datapath
//   mem_din             : read data, non-zero only in the completion cycle of a legal read
//   mem_stall           : access still in progress, pipeline must hold
//   mem_err             : one-cycle pulse in the completion cycle of an illegal access
//   rd_count, wr_count  : saturating counts of completed legal reads / writes
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [15:0] rd_count_q, wr_count_q;
    logic [31:0] ram_q [2**ADDR_WIDTH];
    logic req, legal, done;
    logic [ADDR_WIDTH-1:0] idx;
    logic unused_addr;

    // reset forces every output low even while a request is still presented
    assign req         = (mem_ren | mem_wen) & ~rst;
    assign idx         = mem_addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^mem_addr[31:ADDR_WIDTH+2];
    assign legal       = (mem_addr[1:0] == 2'b00) & ~(mem_ren & mem_wen);
    // completion: countdown exhausted in WAIT, or straight from IDLE when there are no wait states
    assign done        = req & ((state_q == WAIT) ? (cnt_q == 4'd0) : (WAIT_CYCLES == 0));
    assign mem_stall   = req & ~done;
    assign mem_err     = done & ~legal;
    assign mem_din     = (done & legal & mem_ren) ? ram_q[idx] : 32'd0;
    assign rd_count    = rd_count_q;
    assign wr_count    = wr_count_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (req && WAIT_CYCLES != 0) begin
                state_d = WAIT;
                cnt_d   = 4'(WAIT_CYCLES - 1);
            end
        end else if (!req || cnt_q == 4'd0) begin
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (done && legal && mem_ren && rd_count_q != 16'hFFFF)
                rd_count_q <= rd_count_q + 16'd1;
            if (done && legal && mem_wen && wr_count_q != 16'hFFFF)
                wr_count_q <= wr_count_q + 16'd1;
        end
    end

    // array is not reset; only completion cycles of legal writes reach it
    always_ff @(posedge clk) begin
        if (done && legal && mem_wen)
            ram_q[idx] <= mem_dout;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random checks of dmem_responder at WAIT_CYCLES 2, 0 and 3
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        ren [3];
    logic        wen [3];
    logic [31:0] addr [3];
    logic [31:0] dout [3];
    logic [31:0] din [3];
    logic        stall [3];
    logic        err [3];
    logic [15:0] rdc [3];
    logic [15:0] wrc [3];

    int total = 0;
    int bad = 0;
    logic [31:0] m [3][1024];
    int mrd [3];
    int mwr [3];

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .mem_ren(ren[0]), .mem_wen(wen[0]), .mem_addr(addr[0]),
        .mem_dout(dout[0]), .mem_din(din[0]), .mem_stall(stall[0]), .mem_err(err[0]),
        .rd_count(rdc[0]), .wr_count(wrc[0]));
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .mem_ren(ren[1]), .mem_wen(wen[1]), .mem_addr(addr[1]),
        .mem_dout(dout[1]), .mem_din(din[1]), .mem_stall(stall[1]), .mem_err(err[1]),
        .rd_count(rdc[1]), .wr_count(wrc[1]));
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u2 (
        .clk(clk), .rst(rst), .mem_ren(ren[2]), .mem_wen(wen[2]), .mem_addr(addr[2]),
        .mem_dout(dout[2]), .mem_din(din[2]), .mem_stall(stall[2]), .mem_err(err[2]),
        .rd_count(rdc[2]), .wr_count(wrc[2]));

    always #5 clk = ~clk;

    function automatic int wc(int u);
        return u == 0 ? 2 : (u == 1 ? 0 : 3);
    endfunction

    function automatic int ix(logic [31:0] a);
        return int'((a / 32'd4) % 32'd1024);
    endfunction

    function automatic int sat(int v);
        return v < 65535 ? v + 1 : 65535;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(int u);
        ren[u] = 1'b0;
        wen[u] = 1'b0;
        addr[u] = 32'd0;
        dout[u] = 32'd0;
        @(negedge clk);
        chk("idle_stall", 32'(stall[u]), 32'd0);
        chk("idle_din", din[u], 32'd0);
        @(posedge clk);
        #1;
    endtask

    // one access from request to completion; model updates at the closing edge
    task automatic access(int u, bit r, bit w, logic [31:0] a, logic [31:0] d);
        bit ok;
        ok = (a[1:0] == 2'b00) && !(r && w);
        ren[u] = r;
        wen[u] = w;
        addr[u] = a;
        dout[u] = d;
        for (int k = 0; k <= wc(u); k++) begin
            @(negedge clk);
            chk("stall", 32'(stall[u]), 32'(k < wc(u)));
            chk("err", 32'(err[u]), 32'(k == wc(u) && !ok));
            if (k == wc(u)) chk("din", din[u], (r && ok) ? m[u][ix(a)] : 32'd0);
            @(posedge clk);
            #1;
        end
        if (ok && w) begin
            m[u][ix(a)] = d;
            mwr[u] = sat(mwr[u]);
        end
        if (ok && r) mrd[u] = sat(mrd[u]);
        chk("rd_count", 32'(rdc[u]), 32'(mrd[u]));
        chk("wr_count", 32'(wrc[u]), 32'(mwr[u]));
    endtask

    initial begin
        int s;
        int n;
        logic [31:0] a;
        for (int u = 0; u < 3; u++) begin
            ren[u] = 1'b0;
            wen[u] = 1'b0;
            addr[u] = 32'd0;
            dout[u] = 32'd0;
            mrd[u] = 0;
            mwr[u] = 0;
        end
        rst = 1'b1;
        ren[0] = 1'b1;
        addr[0] = 32'h10;
        #12;
        chk("rst_stall", 32'(stall[0]), 32'd0);
        chk("rst_din", din[0], 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        chk("rst_rdc", 32'(rdc[0]), 32'd0);
        chk("rst_wrc", 32'(wrc[0]), 32'd0);
        ren[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        access(0, 0, 1, 32'h10, 32'h1234_5678);
        access(0, 1, 0, 32'h10, 32'd0);
        idle(0);

        access(1, 0, 1, 32'h0, 32'hAAAA_0001);
        access(1, 0, 1, 32'h4, 32'hBBBB_0002);
        access(1, 1, 0, 32'h0, 32'd0);
        access(1, 1, 0, 32'h4, 32'd0);
        idle(1);

        access(0, 0, 1, 32'h12, 32'hDEAD_BEEF);
        access(0, 1, 0, 32'h10, 32'd0);
        access(0, 1, 1, 32'h20, 32'h0BAD_0BAD);
        idle(0);

        access(1, 0, 1, 32'h1000, 32'h0000_CAFE);
        access(1, 1, 0, 32'h0, 32'd0);
        idle(1);

        access(2, 0, 1, 32'h8, 32'h5555_5555);
        wen[2] = 1'b1;
        addr[2] = 32'h8;
        dout[2] = 32'h9999_9999;
        @(negedge clk);
        chk("drop_stall_hi", 32'(stall[2]), 32'd1);
        @(posedge clk);
        #1;
        wen[2] = 1'b0;
        #1;
        chk("drop_stall_lo", 32'(stall[2]), 32'd0);
        @(posedge clk);
        #1;
        chk("drop_wrc", 32'(wrc[2]), 32'(mwr[2]));
        access(2, 1, 0, 32'h8, 32'd0);
        idle(2);

        for (int i = 0; i < 16; i++) access(0, 0, 1, 32'(i * 4), $urandom);
        for (int i = 0; i < 40; i++) begin
            s = int'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 15)) * 32'd4 | (32'($urandom_range(0, 3)) << 12);
            if (s == 6) a = a + 32'($urandom_range(1, 3));
            access(0, (s >= 3 && s <= 5) || s == 7, s <= 2 || s >= 6, a, $urandom);
        end
        idle(0);

        access(0, 0, 1, 32'h40, 32'h0000_1111);
        wen[0] = 1'b1;
        addr[0] = 32'h40;
        dout[0] = 32'h0000_2222;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stall[0]), 32'd0);
        chk("mid_rst_din", din[0], 32'd0);
        chk("mid_rst_err", 32'(err[0]), 32'd0);
        chk("mid_rst_rdc", 32'(rdc[0]), 32'd0);
        chk("mid_rst_wrc", 32'(wrc[0]), 32'd0);
        for (int u = 0; u < 3; u++) begin
            mrd[u] = 0;
            mwr[u] = 0;
        end
        #1;
        wen[0] = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        access(0, 1, 0, 32'h40, 32'd0);
        access(0, 0, 1, 32'h44, 32'h0000_0007);
        idle(0);

        n = 65534 - mrd[1];
        ren[1] = 1'b1;
        addr[1] = 32'h0;
        repeat (n) @(posedge clk);
        #1;
        mrd[1] = 65534;
        chk("preload_rdc", 32'(rdc[1]), 32'(mrd[1]));
        repeat (3) access(1, 1, 0, 32'h0, 32'd0);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
